bcd_time_counter: RTL and testbench

Time-of-day counter stage for the digital clock. It consumes the single-cycle 1 Hz enable pulse from the prescaler/divider chain and maintains hh:mm:ss as BCD digits, with a set mode for adjusting minutes and hours. It sits between the flip-flop-based divider chain and the seven-segment decode/display stage, driving the digit outputs that stage consumes.

---
 rtl/clock_pkg.sv | 23 ++
 rtl/bcd_digit.sv | 29 ++
 rtl/bcd_time_counter.sv | 147 ++++++++++++++
 tb/tb_bcd_time_counter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - digit limits, BCD digit type and hour encodings for the time counter
package clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t MIN_TENS_MAX = 4'd5;
    localparam bcd_t DEC_MAX      = 4'd9;
    localparam int   HR24_MAX     = 23;
    localparam int   HR12_MIN     = 1;
    localparam int   HR12_MAX     = 12;

    // Packs a two-digit decimal value as {tens, ones} BCD.
    function automatic logic [7:0] bcd_pair(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    localparam logic [7:0] HR24_MAX_BCD  = bcd_pair(HR24_MAX);
    localparam logic [7:0] HR12_MIN_BCD  = bcd_pair(HR12_MIN);
    localparam logic [7:0] HR12_MAX_BCD  = bcd_pair(HR12_MAX);
    localparam logic [7:0] HR12_FLIP_BCD = bcd_pair(HR12_MAX - 1);

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one mod-(max+1) BCD digit with enable, synchronous clear and carry out
module bcd_digit
    import clock_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    input  bcd_t i_max,
    output bcd_t o_value,
    output logic o_carry
);

    bcd_t r_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= 4'd0;
        end else if (i_clr) begin
            r_value <= 4'd0;
        end else if (i_en) begin
            r_value <= (r_value == i_max) ? 4'd0 : r_value + 4'd1;
        end
    end

    assign o_value = r_value;
    assign o_carry = i_en & (r_value == i_max);

endmodule

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - hh:mm:ss BCD time-of-day counter with set mode and 12/24h hours
module bcd_time_counter
    import clock_pkg::*;
#(
    parameter bit MODE_24H = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       run_en,
    input  logic       set_mode,
    input  logic       inc_min,
    input  logic       inc_hr,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [3:0] hr_ones,
    output logic [3:0] hr_tens,
    output logic       pm,
    output logic       day_rollover
);

    localparam logic [7:0] HR_RESET_BCD = MODE_24H ? 8'h00 : HR12_MAX_BCD;

    logic       r_set_q;
    bcd_t       r_hr_tens;
    bcd_t       r_hr_ones;
    logic       r_pm;
    logic       r_day_rollover;

    logic       w_set_exit;
    logic       w_run;
    logic       w_sec_ones_c;
    logic       w_sec_tens_c;
    logic       w_min_ones_c;
    logic       w_min_tens_c;
    logic       w_min_en;
    logic       w_hr_en;
    logic       w_midnight;
    logic [7:0] w_hr;
    bcd_t       w_hr_tens_nxt;
    bcd_t       w_hr_ones_nxt;
    logic       w_pm_nxt;

    // The tick landing on the set-mode exit edge is dropped so the next one reads :01.
    assign w_set_exit = r_set_q & ~set_mode;
    assign w_run      = ~set_mode & run_en & tick & ~w_set_exit;
    assign w_min_en   = (w_run & w_sec_tens_c) | (set_mode & inc_min);
    assign w_hr_en    = (w_run & w_min_tens_c) | (set_mode & inc_hr);
    assign w_hr       = {r_hr_tens, r_hr_ones};

    bcd_digit u_sec_ones (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_set_exit),
        .i_en    (w_run),
        .i_max   (DEC_MAX),
        .o_value (sec_ones),
        .o_carry (w_sec_ones_c)
    );

    bcd_digit u_sec_tens (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_set_exit),
        .i_en    (w_sec_ones_c),
        .i_max   (SEC_TENS_MAX),
        .o_value (sec_tens),
        .o_carry (w_sec_tens_c)
    );

    bcd_digit u_min_ones (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (1'b0),
        .i_en    (w_min_en),
        .i_max   (DEC_MAX),
        .o_value (min_ones),
        .o_carry (w_min_ones_c)
    );

    bcd_digit u_min_tens (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (1'b0),
        .i_en    (w_min_ones_c),
        .i_max   (MIN_TENS_MAX),
        .o_value (min_tens),
        .o_carry (w_min_tens_c)
    );

    always_comb begin
        w_hr_tens_nxt = r_hr_tens;
        w_hr_ones_nxt = r_hr_ones;
        w_pm_nxt      = r_pm;
        if (MODE_24H) begin
            if (w_hr == HR24_MAX_BCD) begin
                {w_hr_tens_nxt, w_hr_ones_nxt} = 8'h00;
            end else if (r_hr_ones == DEC_MAX) begin
                w_hr_tens_nxt = r_hr_tens + 4'd1;
                w_hr_ones_nxt = 4'd0;
            end else begin
                w_hr_ones_nxt = r_hr_ones + 4'd1;
            end
        end else begin
            // 12 is followed by 01; the AM/PM flip happens entering 12, not leaving it.
            if (w_hr == HR12_MAX_BCD) begin
                {w_hr_tens_nxt, w_hr_ones_nxt} = HR12_MIN_BCD;
            end else if (w_hr == HR12_FLIP_BCD) begin
                {w_hr_tens_nxt, w_hr_ones_nxt} = HR12_MAX_BCD;
                w_pm_nxt = ~r_pm;
            end else if (r_hr_ones == DEC_MAX) begin
                w_hr_tens_nxt = r_hr_tens + 4'd1;
                w_hr_ones_nxt = 4'd0;
            end else begin
                w_hr_ones_nxt = r_hr_ones + 4'd1;
            end
        end
    end

    assign w_midnight = w_run & w_min_tens_c &
                        (MODE_24H ? (w_hr == HR24_MAX_BCD) : ((w_hr == HR12_FLIP_BCD) & r_pm));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_set_q                <= 1'b0;
            {r_hr_tens, r_hr_ones} <= HR_RESET_BCD;
            r_pm                   <= 1'b0;
            r_day_rollover         <= 1'b0;
        end else begin
            r_set_q        <= set_mode;
            r_day_rollover <= w_midnight;
            if (w_hr_en) begin
                r_hr_tens <= w_hr_tens_nxt;
                r_hr_ones <= w_hr_ones_nxt;
                r_pm      <= w_pm_nxt;
            end
        end
    end

    assign hr_tens      = r_hr_tens;
    assign hr_ones      = r_hr_ones;
    assign pm           = MODE_24H ? 1'b0 : r_pm;
    assign day_rollover = r_day_rollover;

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb/tb_bcd_time_counter.sv - self-checking bench for bcd_time_counter in 24h and 12h builds
module tb_bcd_time_counter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b0;
    logic run_en = 1'b0;
    logic set_mode = 1'b0;
    logic inc_min = 1'b0;
    logic inc_hr = 1'b0;

    logic [3:0] s1_24, s10_24, m1_24, m10_24, h1_24, h10_24;
    logic       pm_24, roll_24;
    logic [3:0] s1_12, s10_12, m1_12, m10_12, h1_12, h10_12;
    logic       pm_12, roll_12;

    int checks = 0;
    int errors = 0;

    // Reference state: one 24h time of day; the 12h display is derived from it.
    int  m_h = 0, m_m = 0, m_s = 0;
    bit  m_roll = 0;
    bit  m_prev_set = 0;

    always #5 clk = ~clk;

    bcd_time_counter #(.MODE_24H(1'b1)) dut24 (
        .clk(clk), .reset(reset), .tick(tick), .run_en(run_en), .set_mode(set_mode),
        .inc_min(inc_min), .inc_hr(inc_hr),
        .sec_ones(s1_24), .sec_tens(s10_24), .min_ones(m1_24), .min_tens(m10_24),
        .hr_ones(h1_24), .hr_tens(h10_24), .pm(pm_24), .day_rollover(roll_24)
    );

    bcd_time_counter #(.MODE_24H(1'b0)) dut12 (
        .clk(clk), .reset(reset), .tick(tick), .run_en(run_en), .set_mode(set_mode),
        .inc_min(inc_min), .inc_hr(inc_hr),
        .sec_ones(s1_12), .sec_tens(s10_12), .min_ones(m1_12), .min_tens(m10_12),
        .hr_ones(h1_12), .hr_tens(h10_12), .pm(pm_12), .day_rollover(roll_12)
    );

    wire [23:0] t24 = {h10_24, h1_24, m10_24, m1_24, s10_24, s1_24};
    wire [24:0] t12 = {pm_12, h10_12, h1_12, m10_12, m1_12, s10_12, s1_12};

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int h12(input int h);
        return (h % 12 == 0) ? 12 : h % 12;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model step on every rising edge, then compare once the registers have settled.
    always @(posedge clk) begin
        if (reset) begin
            m_h = 0; m_m = 0; m_s = 0; m_roll = 0; m_prev_set = 0;
        end else begin
            m_roll = 0;
            if (set_mode) begin
                if (inc_min) m_m = (m_m + 1) % 60;
                if (inc_hr)  m_h = (m_h + 1) % 24;
            end else if (m_prev_set) begin
                m_s = 0;
            end else if (run_en && tick) begin
                int t;
                t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
                m_roll = (t == 0);
            end
            m_prev_set = set_mode;
        end
        #1;
        check("time24", t24, {bcd2(m_h), bcd2(m_m), bcd2(m_s)});
        check("pm24", pm_24, 0);
        check("roll24", roll_24, m_roll);
        check("time12", t12, {(m_h >= 12) ? 1'b1 : 1'b0, bcd2(h12(m_h)), bcd2(m_m), bcd2(m_s)});
        check("roll12", roll_12, m_roll);
    end

    task automatic cyc(input logic rst, input logic tk, input logic ren,
                       input logic sm, input logic im, input logic ih);
        reset = rst; tick = tk; run_en = ren; set_mode = sm; inc_min = im; inc_hr = ih;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 1, 0, 0, 0);
    endtask

    // Reach hh:mm:ss through set mode, a set-mode exit with a tick present, then plain ticks.
    task automatic goto_time(input int th, input int tm, input int ts);
        cyc(0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 30 && m_h != th; i++) cyc(0, 1, 1, 1, 0, 1);
        for (int i = 0; i < 70 && m_m != tm; i++) cyc(0, 1, 1, 1, 1, 0);
        cyc(0, 1, 1, 0, 0, 0);
        ticks(ts);
    endtask

    initial begin
        int sm_state;
        @(negedge clk);

        cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        check("lit_reset24", t24, 24'h000000);
        check("lit_reset12", t12, {1'b0, 24'h120000});
        check("lit_reset_roll", {roll_24, roll_12}, 2'b00);

        ticks(59);
        check("lit_000059", t24, 24'h000059);
        ticks(1);
        check("lit_000100", t24, 24'h000100);
        check("lit_model_min", m_m, 1);

        goto_time(0, 59, 59);
        ticks(1);
        check("lit_010000", t24, 24'h010000);
        check("lit_010000_12", t12, {1'b0, 24'h010000});

        goto_time(23, 59, 59);
        check("lit_235959_12", t12, {1'b1, 24'h115959});
        ticks(1);
        check("lit_midnight24", t24, 24'h000000);
        check("lit_midnight12", t12, {1'b0, 24'h120000});
        check("lit_midnight_roll", {roll_24, roll_12}, 2'b11);
        cyc(0, 0, 1, 0, 0, 0);
        check("lit_roll_one_clk", {roll_24, roll_12}, 2'b00);

        goto_time(11, 59, 59);
        ticks(1);
        check("lit_noon12", t12, {1'b1, 24'h120000});
        check("lit_noon_roll", {roll_24, roll_12}, 2'b00);

        goto_time(0, 0, 30);
        for (int i = 0; i < 61; i++) cyc(0, 1, 1, 1, 1, (i < 3) ? 1'b1 : 1'b0);
        check("lit_set_030130", t24, 24'h030130);
        check("lit_set_030130_12", t12, {1'b0, 24'h030130});
        cyc(0, 1, 1, 0, 0, 0);
        check("lit_exit_030100", t24, 24'h030100);
        ticks(1);
        check("lit_030101", t24, 24'h030101);

        goto_time(23, 59, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 1, 1);
        check("lit_simul_0000", t24, 24'h000000);
        check("lit_simul_noroll", {roll_24, roll_12}, 2'b00);
        cyc(0, 0, 1, 0, 0, 0);
        ticks(7);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0);
        check("lit_run_en_hold", t24, 24'h000007);

        goto_time(12, 34, 56);
        check("lit_123456_12", t12, {1'b1, 24'h123456});
        cyc(1, 1, 1, 0, 0, 0);
        check("lit_reset_mid24", t24, 24'h000000);
        check("lit_reset_mid12", t12, {1'b0, 24'h120000});
        check("lit_reset_mid_roll", {roll_24, roll_12}, 2'b00);

        sm_state = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 600 == 599) begin
                goto_time(23, 59, $urandom_range(50, 59));
                sm_state = 0;
            end
            if ($urandom_range(0, 49) == 0) sm_state = 1 - sm_state;
            cyc(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
                1'(sm_state),
                ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        end

        cyc(0, 0, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
